// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared types and constants for the ARM pipeline memory stage.
//               Holds the data-memory FSM state type, the memory map
//               defaults and the range-check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'd1024;
  localparam int          DMEM_DEPTH     = 64;

  // Range check done in 33 bits so neither the lower bound (addresses below
  // base) nor the upper bound (base + 4*depth near 2^32) can wrap.
  function automatic logic dmem_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          depth);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(depth) << 2);
    return (a >= lo) && (a < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl_if
// Description : Memory-stage bus between the execute-stage register (master)
//               and the data-memory controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        freeze;
  logic        addr_err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, freeze, addr_err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, freeze, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port 32-bit word RAM, synchronous write, asynchronous
//               read. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];

  // Word write on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Memory-stage data-memory controller. With DMEM_WAIT_EN
//               defined it models a slow store with WAIT_CYCLES wait states
//               and stalls the pipeline through freeze; otherwise it is a
//               zero-wait memory with combinational load data.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
  import arm_pkg::*;
#(
  parameter int          WAIT_CYCLES = 4,
  parameter int          DEPTH       = DMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic          w_req;
  logic          w_arr_we;
  logic [AW-1:0] w_arr_idx;
  logic [31:0]   w_arr_wdata;
  logic [31:0]   w_arr_rdata;

  // Byte address to word index; the low two address bits drop out here.
  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  assign w_req = bus.mem_read | bus.mem_write;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (w_arr_we),
    .addr  (w_arr_idx),
    .wdata (w_arr_wdata),
    .rdata (w_arr_rdata)
  );

`ifdef DMEM_WAIT_EN
  dmem_state_t      r_state;
  dmem_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_is_store;
  logic             r_err;
  logic             w_capture;
  logic             w_finish;
  logic             w_in_range;

  // Everything after capture works on the latched operands, so the
  // execute stage may change its outputs while the access is in flight.
  assign w_in_range  = dmem_in_range(r_addr, BASE_ADDR, DEPTH);
  assign w_arr_idx   = word_idx(r_addr);
  assign w_arr_wdata = r_wdata;
  // Reset on the completing edge aborts the store as well.
  assign w_arr_we    = w_finish & r_is_store & w_in_range & ~rst;

  // State, counter, captured operands and completion results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_store <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_addr     <= bus.addr;
        r_wdata    <= bus.wdata;
        r_is_store <= bus.mem_write;
      end
      if (w_finish) begin
        r_err <= ~w_in_range;
        if (!r_is_store) begin
          r_rdata <= w_in_range ? w_arr_rdata : '0;
        end
      end
    end
  end

  // Next-state and counter logic; completion fires on the last BUSY cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ready    = (r_state == DONE);
  assign bus.addr_err = (r_state == DONE) & r_err;
  // Dropping freeze in DONE lets the pipeline advance at the end of DONE.
  assign bus.freeze   = w_req & (r_state != DONE);
  assign bus.rdata    = r_rdata;
`else
  logic w_in_range;

  assign w_in_range   = dmem_in_range(bus.addr, BASE_ADDR, DEPTH);
  assign w_arr_idx    = word_idx(bus.addr);
  assign w_arr_wdata  = bus.wdata;
  assign w_arr_we     = bus.mem_write & w_in_range & ~rst;
  assign bus.ready    = w_req;
  assign bus.freeze   = 1'b0;
  assign bus.addr_err = w_req & ~w_in_range;
  // A store wins when both controls are high, so only a pure load returns data.
  assign bus.rdata    = (bus.mem_read & ~bus.mem_write & w_in_range) ? w_arr_rdata : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Scoreboard bench for data_mem_ctrl with a word-array
//               reference model and randomized loads/stores. Honours
//               DMEM_WAIT_EN for the expected latency and freeze behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int          W     = 4;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd1024;
`ifdef DMEM_WAIT_EN
  localparam int   LAT         = W + 1;
  localparam logic BUSY_FREEZE = 1'b1;
`else
  localparam int   LAT         = 0;
  localparam logic BUSY_FREEZE = 1'b0;
`endif

  typedef struct packed {
    logic        is_load;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(
    .WAIT_CYCLES (W),
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned la;
    la = 64'(a);
    return (la >= 64'(BASE)) && (la < 64'(BASE) + 64'(4 * DEPTH));
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // Issue one access, record its expected response, wait for ready.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   cyc;
    bit   ok;
    bit   done;
    ok        = in_rng(a);
    e.is_load = rd & ~wr;
    e.err     = ~ok;
    e.addr    = a;
    e.rdata   = (e.is_load && ok) ? model[idx(a)] : 32'h0;
    sb.push_back(e);
    if (wr && ok) model[idx(a)] = d;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = d;
    cyc  = 0;
    done = 0;
    while (!done && cyc <= LAT + 10) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        done = 1;
        check("latency", 32'(cyc), 32'(LAT));
        check("freeze_at_ready", {31'b0, bus.freeze}, 32'h0);
      end else begin
        check("freeze_wait", {31'b0, bus.freeze}, {31'b0, BUSY_FREEZE});
        cyc++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: no ready after %0d cycles for addr 0x%08h", cyc, a);
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_freeze", {31'b0, bus.freeze}, 32'h0);
      check("idle_ready", {31'b0, bus.ready}, 32'h0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"},  {31'b0, bus.ready},    32'h0);
    check({tag, "_err"},    {31'b0, bus.addr_err}, 32'h0);
    check({tag, "_rdata"},  bus.rdata,             32'h0);
    check({tag, "_freeze"}, {31'b0, bus.freeze},   32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 32'($urandom_range(0, 1023));
      1:       return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 1000));
      2:       return 32'hFFFF_FFFC;
      default: return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
    endcase
  endfunction

  // Monitor: every ready pulse retires the oldest expected response.
  exp_t m_e;
  always @(negedge clk) begin
    if (bus.ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: ready with empty scoreboard at %0t", $time);
      end else begin
        m_e = sb.pop_front();
        check("addr_err", {31'b0, bus.addr_err}, {31'b0, m_e.err});
        if (m_e.is_load) check("rdata", bus.rdata, m_e.rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b1, BASE + 32'(4 * i), $urandom);

    do_op(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b0, 32'd1024, 32'h0);
    do_op(1'b1, 1'b0, 32'd1280, 32'h0);
    do_op(1'b0, 1'b1, 32'd1020, 32'h0BAD_0BAD);
    do_op(1'b1, 1'b0, 32'd1276, 32'h0);
    idle(1);

`ifdef DMEM_WAIT_EN
    // Store to word 1, then reset during the second BUSY cycle.
    bus.mem_write = 1'b1;
    bus.addr      = 32'd1028;
    bus.wdata     = 32'h1234_5678;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.mem_write = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid");
    @(posedge clk);
    #1;
`else
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_idle");
    @(posedge clk);
    #1;
`endif
    do_op(1'b1, 1'b0, 32'd1028, 32'h0);

    do_op(1'b1, 1'b1, 32'd1032, 32'hA5A5_A5A5);
    do_op(1'b1, 1'b0, 32'd1032, 32'h0);

    do_op(1'b0, 1'b1, 32'd1036, 32'h0000_0055);
    do_op(1'b1, 1'b0, 32'd1036, 32'h0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 3);
      case (k)
        0:       do_op(1'b1, 1'b0, rand_addr(), $urandom);
        1:       do_op(1'b0, 1'b1, rand_addr(), $urandom);
        2:       do_op(1'b1, 1'b1, rand_addr(), $urandom);
        default: do_op(1'b1, 1'b0, rand_addr(), $urandom);
      endcase
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end

    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, BASE + 32'(4 * i), 32'h0);

    idle(2);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data-memory controller for the memory stage of the ARM pipeline, between the execute-stage register and the memory-stage register. It takes the ALU result as the byte address, `val_Rm` as store data, and the `mem_read`/`mem_write` controls. It models a slow SRAM-like store with a fixed wait count. While an access is outstanding it raises `freeze`, which stalls every upstream stage register and the PC.

## Interface
- `WAIT_CYCLES`, default 4: wait states per access; must be ≥1.
- `DEPTH`, default 64: number of 32-bit words.
- `BASE_ADDR`, default 1024: byte address of word 0.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load request from the execute-stage register.
- `mem_write`  in  1  store request from the execute-stage register.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (`val_Rm`).
- `rdata`  out  32  load data; valid while `ready`=1.
- `ready`  out  1  access completes this cycle.
- `freeze`  out  1  stall request to the IF/ID/EXE registers and the PC.
- `addr_err`  out  1  out-of-range access; pulses with `ready`.

## Operation
- The request is `req = mem_read | mem_write`.
- If both controls are high, the access is a store and the read is ignored.
- Word index is `(addr - BASE_ADDR) >> 2`.
  - `addr[1:0]` is ignored.
  - The address is in range when `BASE_ADDR ≤ addr < BASE_ADDR + 4*DEPTH`.
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `req` is high: capture `addr`, `wdata` and the op; load `cnt <= WAIT_CYCLES-1`; go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`, using the captured operands:
    - Store in range: write the array.
    - Load in range: register the array word into `rdata`.
    - Out of range: drop the store; load gives `rdata = 0`.
    - Set the error flag when out of range.
    - Go to DONE.
- **DONE**
  - `ready = 1`.
  - `addr_err` = error flag.
  - Next state is IDLE unconditionally.
- `freeze = req & (state != DONE)`, combinational.
  - This lets the pipeline advance at the end of DONE.
  - The next instruction's request is then sampled in IDLE.
- The array is not reset; its contents survive `rst`.

## Timing
- A request that first appears in cycle 0:
  - `freeze` is high in cycles 0 to WAIT_CYCLES.
  - `ready` is high in cycle WAIT_CYCLES+1.
  - Stall penalty is WAIT_CYCLES+1 cycles.
- Back-to-back accesses: the second request is sampled in the cycle after DONE, so there is a one-cycle IDLE gap with `freeze` high.
- `rdata` holds its value until the next load completes. It is 0 after reset.
- A non-memory instruction in IDLE has `freeze` = 0 and costs no penalty.
- Inputs change while BUSY: no effect, because the captured operands are used.
- Reset:
  - Reset values: `rdata` = 0, `ready` = 0, `addr_err` = 0, `freeze` follows `req` combinationally from IDLE, `cnt` = 0, state = IDLE.
  - Reset during BUSY aborts the access. No array write occurs.
- `req` falling in DONE is harmless; the FSM returns to IDLE.

## Configuration
- `DMEM_WAIT_EN` defined: the FSM, wait counter and `freeze` behaviour described above.
- `DMEM_WAIT_EN` undefined: zero-wait memory.
  - `freeze` is tied to 0; `ready = req`.
  - Store writes on the rising edge of the request cycle.
  - Load data is combinational from the array.
  - `addr_err` is combinational for the current request.
  - The FSM and counter are not compiled.

## Structure
- Shared package `arm_pkg` holds:
  - the state enum `dmem_state_t` (IDLE/BUSY/DONE);
  - `DMEM_BASE_ADDR` and `DMEM_DEPTH` constants, used as parameter defaults.
- One sub-module, `dmem_array`: single-port 32-bit word RAM with synchronous write and asynchronous read, parameterised by depth.
- The FSM, counter and range check live in `data_mem_ctrl`.

## Test plan
- **Store:** `mem_write`=1, `addr`=1024, `wdata`=0xDEADBEEF, `WAIT_CYCLES`=4.
  - `freeze` high for 5 cycles; `ready` pulses in cycle 5.
  - Array word 0 = 0xDEADBEEF.
- **Load:** `mem_read`=1, `addr`=1024, after the store above.
  - `ready` in cycle 5 with `rdata`=0xDEADBEEF; `addr_err`=0.
- **Out of range:** load at `addr`=1024+256=1280.
  - `rdata`=0 and `addr_err`=1 with `ready`.
  - A store to 1020 leaves all words unchanged.
- **Reset mid-access:** store 0x12345678 to 1028, assert `rst` in BUSY cycle 2.
  - State returns to IDLE; word 1 keeps its old value.
  - Outputs are 0 the following cycle.
- **Both controls high:** `mem_read`=`mem_write`=1, `addr`=1032, `wdata`=0xA5A5A5A5.
  - Treated as a store; word 2 = 0xA5A5A5A5.
- **`DMEM_WAIT_EN` undefined:** back-to-back store 0x55 then load at 1036.
  - `freeze` never asserts.
  - The load returns 0x55 in the same cycle it is presented.
